sequence_readback_checker: RTL and testbench
============================================

Name: sequence_readback_checker

Overview:
- Read side of the Memory Tester storage path: walks stored 4-bit entries from address 0 upward and presents each read to the compare logic.
- Compares each stored nibble with the player's guess.
- Counts correct guesses and stops on the first miss or after the last entry.
- Sits between the nibble storage array (load-register bank) and the game controller/display.

Parameters:
- DATA_W, 4, width of each stored entry and of guess.
- ADDR_W, 4, storage address width.
- NUM_ITEMS, 16, number of entries checked per round (1..2**ADDR_W).
- RD_LAT, 1, cycles from mem_rd to valid mem_data (1..4).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  block enable; low forces IDLE and clears state
- logout  in  1  synchronous abort of current round
- start  in  1  begin a round (level-sampled, acted on in IDLE/DONE only)
- guess  in  DATA_W  player entry
- guess_valid  in  1  one-cycle strobe qualifying guess
- mem_addr  out  ADDR_W  storage read address
- mem_rd  out  1  one-cycle read strobe
- mem_data  in  DATA_W  storage read data, valid RD_LAT cycles after mem_rd
- busy  out  1  high in FETCH/WAIT/CHECK
- match  out  1  one-cycle pulse on correct guess
- mismatch  out  1  one-cycle pulse on wrong guess
- score  out  ADDR_W+1  correct guesses this round
- done  out  1  level, high in DONE
- pass  out  1  level, valid while done: 1 = all NUM_ITEMS matched

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge): state IDLE, mem_addr=0, mem_rd=0, busy=0, match=0, mismatch=0, score=0, done=0, pass=0.
- Priority: rst > enable=0 > logout > normal operation.
- enable=0 or logout=1: next state is IDLE, with the same values as reset.
  - Takes effect from any state, including mid-WAIT. Any outstanding read data is discarded.
- States:
  - IDLE: on start=1, go to FETCH. Set index=0, score=0.
  - FETCH: one cycle. mem_rd=1, mem_addr=index. Load the wait counter with RD_LAT. Go to WAIT.
  - WAIT: count down RD_LAT cycles. On the cycle mem_data is valid, capture it into the expected register and go to CHECK.
  - CHECK: hold until guess_valid=1.
    - If guess == expected: match=1 for one cycle and score+1.
      - If index == NUM_ITEMS-1: go to DONE with pass=1.
      - Otherwise: index+1 and go to FETCH.
    - If guess != expected: mismatch=1 for one cycle. Go to DONE with pass=0. Score is unchanged.
  - DONE: done=1; pass and score hold. On start=1: clear score, done and pass; set index=0; go to FETCH.
- guess_valid outside CHECK is ignored, with no pulse and no score change.
- start outside IDLE/DONE is ignored.
- Latency with start sampled at edge t:
  - mem_rd high in cycle t+1.
  - Capture at t+1+RD_LAT.
  - CHECK from the following cycle.
  - match/mismatch asserted in the cycle after the guess_valid edge.
- score never exceeds NUM_ITEMS, so there is no wrap.
- mem_addr holds its last value outside FETCH.
- NUM_ITEMS=1 edge case: a single FETCH/CHECK, then DONE.

Decomposition:
- Shared package (game_pkg): DATA_W, ADDR_W defaults; the state encoding constants (IDLE, FETCH, WAIT, CHECK, DONE); score width derivation.
- One sub-module is natural: rd_wait_counter.
  - Loadable down-counter with load, count and zero-flag outputs.
  - Reusable for other latency-matched reads in the game.
- Compare and score logic stays inline.

Test Plan:
- NUM_ITEMS=4, RD_LAT=1, memory [3,7,0,F], guesses 3,7,0,F -> four match pulses, mem_addr 0..3, score=4, done=1, pass=1.
- Same memory, guesses 3,5 -> match then mismatch at index 1, score=1, done=1, pass=0, no further mem_rd.
- RD_LAT=3, guess_valid strobed during WAIT with the correct value -> ignored. A later strobe in CHECK -> match, score=1.
- logout=1 in CHECK at index 2 -> next cycle state IDLE, score=0, busy=0, done=0. A subsequent start reads from address 0.
- rst=1 mid-WAIT, then release with start=1 -> all outputs at reset values, then mem_rd with mem_addr=0 one cycle after start.
- DONE with pass=1, start pulsed -> score cleared to 0, done=0, new round begins at address 0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_pkg : shared widths, read-checker state encoding, score width helper
// Rev 1.0
// ----------------------------------------------------------------------------
package game_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int LAT_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // One extra bit so a perfect round (score == 2**ADDR_W) never wraps
  function automatic int score_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_wait_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rd_wait_counter : loadable down-counter with zero flag for read latency
// Rev 1.0
// ----------------------------------------------------------------------------
module rd_wait_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sequence_readback_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sequence_readback_checker : walks stored nibbles, compares guesses, scores
// Rev 1.0
// ----------------------------------------------------------------------------
module sequence_readback_checker
  import game_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_ITEMS = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      logout,
  input  logic                      start,
  input  logic [DATA_W-1:0]         guess,
  input  logic                      guess_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      busy,
  output logic                      match,
  output logic                      mismatch,
  output logic [score_w(ADDR_W)-1:0] score,
  output logic                      done,
  output logic                      pass
);

  localparam int                SCORE_W  = score_w(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ITEMS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                busy_q, busy_d;
  logic                match_q, match_d;
  logic                mismatch_q, mismatch_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                cnt_load, cnt_count, cnt_zero;

  // Loaded on entry to FETCH and already counting there, so zero lands on the
  // edge where mem_data is valid, RD_LAT cycles after the mem_rd cycle.
  rd_wait_counter #(
    .CNT_W (LAT_W)
  ) u_rd_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    exp_d      = exp_q;
    mem_addr_d = mem_addr_q;
    score_d    = score_q;
    pass_d     = pass_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_count  = 1'b0;

    if (!enable || logout) begin
      state_d    = ST_IDLE;
      index_d    = '0;
      exp_d      = '0;
      mem_addr_d = '0;
      score_d    = '0;
      pass_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_FETCH;
            index_d  = '0;
            score_d  = '0;
            pass_d   = 1'b0;
            cnt_load = 1'b1;
          end
        end
        ST_FETCH: begin
          state_d   = ST_WAIT;
          cnt_count = 1'b1;
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            exp_d   = mem_data;
            state_d = ST_CHECK;
          end else begin
            cnt_count = 1'b1;
          end
        end
        ST_CHECK: begin
          if (guess_valid) begin
            if (guess == exp_q) begin
              match_d = 1'b1;
              score_d = score_q + 1'b1;
              if (index_q == LAST_IDX) begin
                state_d = ST_DONE;
                pass_d  = 1'b1;
              end else begin
                index_d  = index_q + 1'b1;
                state_d  = ST_FETCH;
                cnt_load = 1'b1;
              end
            end else begin
              mismatch_d = 1'b1;
              state_d    = ST_DONE;
              pass_d     = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Status outputs follow the next state so they are registered yet aligned
    mem_rd_d = (state_d == ST_FETCH);
    if (state_d == ST_FETCH) begin
      mem_addr_d = index_d;
    end
    busy_d = (state_d == ST_FETCH) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      exp_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      score_q    <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      exp_q      <= exp_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      busy_q     <= busy_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      score_q    <= score_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign busy     = busy_q;
  assign match    = match_q;
  assign mismatch = mismatch_q;
  assign score    = score_q;
  assign done     = done_q;
  assign pass     = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_readback_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sequence_readback_checker : directed bench, RD_LAT=1 and RD_LAT=3 DUTs
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sequence_readback_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, logout;
  logic       start, guess_valid;
  logic [3:0] guess;
  logic       start3, gv3;
  logic [3:0] guess3;

  logic [3:0] addr1, data1, addr3, data3;
  logic       rd1, busy1, match1, mm1, done1, pass1;
  logic       rd3, busy3, match3, mm3, done3, pass3;
  logic [4:0] score1, score3;

  logic [3:0] mem [0:15];
  logic [3:0] p1_d [0:3];
  logic       p1_v [0:3];
  logic [3:0] p3_d [0:3];
  logic       p3_v [0:3];

  int n_checks = 0;
  int n_fail   = 0;

  sequence_readback_checker #(
    .DATA_W(4), .ADDR_W(4), .NUM_ITEMS(4), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .logout(logout), .start(start),
    .guess(guess), .guess_valid(guess_valid), .mem_addr(addr1), .mem_rd(rd1),
    .mem_data(data1), .busy(busy1), .match(match1), .mismatch(mm1),
    .score(score1), .done(done1), .pass(pass1)
  );

  sequence_readback_checker #(
    .DATA_W(4), .ADDR_W(4), .NUM_ITEMS(4), .RD_LAT(3)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .logout(logout), .start(start3),
    .guess(guess3), .guess_valid(gv3), .mem_addr(addr3), .mem_rd(rd3),
    .mem_data(data3), .busy(busy3), .match(match3), .mismatch(mm3),
    .score(score3), .done(done3), .pass(pass3)
  );

  // Storage model: data valid exactly LAT cycles after mem_rd, else a sentinel
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        p1_v[k] <= 1'b0;
        p3_v[k] <= 1'b0;
      end
    end else begin
      p1_v[0] <= rd1;
      p3_v[0] <= rd3;
      for (int k = 1; k < 4; k++) begin
        p1_v[k] <= p1_v[k-1];
        p3_v[k] <= p3_v[k-1];
      end
    end
    p1_d[0] <= mem[addr1];
    p3_d[0] <= mem[addr3];
    for (int k = 1; k < 4; k++) begin
      p1_d[k] <= p1_d[k-1];
      p3_d[k] <= p3_d[k-1];
    end
  end
  assign data1 = p1_v[0] ? p1_d[0] : 4'h9;
  assign data3 = p3_v[2] ? p3_d[2] : 4'h9;

  logic [14:0] o1, o3;
  assign o1 = {addr1, rd1, busy1, match1, mm1, score1, done1, pass1};
  assign o3 = {addr3, rd3, busy3, match3, mm3, score3, done3, pass3};

  function automatic logic [14:0] ev(input int a, input int rd, input int bz,
                                     input int m, input int mm, input int sc,
                                     input int dn, input int ps);
    return {a[3:0], rd[0], bz[0], m[0], mm[0], sc[4:0], dn[0], ps[0]};
  endfunction

  // Vector order: {mem_addr, mem_rd, busy, match, mismatch, score, done, pass}
  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; logout = 1'b0;
    start = 1'b0; guess_valid = 1'b0; guess = 4'h0;
    start3 = 1'b0; gv3 = 1'b0; guess3 = 4'h0;
    for (int k = 0; k < 16; k++) mem[k] = 4'hC;
    mem[0] = 4'h3; mem[1] = 4'h7; mem[2] = 4'h0; mem[3] = 4'hF;

    tick; tick;
    chk("reset", o1, ev(0,0,0,0,0,0,0,0));
    chk("reset_lat3", o3, ev(0,0,0,0,0,0,0,0));
    rst = 1'b0;

    // Full round, all correct
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_fetch%0d", i), o1, ev(i,1,1,(i > 0),0,i,0,0));
      tick;
      chk($sformatf("t1_wait%0d", i), o1, ev(i,0,1,0,0,i,0,0));
      tick;
      guess = mem[i]; guess_valid = 1'b1; tick; guess_valid = 1'b0;
    end
    chk("t1_done", o1, ev(3,0,0,1,0,4,1,1));
    tick;
    chk("t1_hold", o1, ev(3,0,0,0,0,4,1,1));

    // Restart from DONE with pass, then miss at index 1
    start = 1'b1; tick; start = 1'b0;
    chk("t6_restart", o1, ev(0,1,1,0,0,0,0,0));
    tick; tick;
    guess = 4'h3; guess_valid = 1'b1; tick; guess_valid = 1'b0;
    chk("t2_match0", o1, ev(1,1,1,1,0,1,0,0));
    tick; tick;
    guess = 4'h5; guess_valid = 1'b1; tick; guess_valid = 1'b0;
    chk("t2_miss", o1, ev(1,0,0,0,1,1,1,0));
    guess = 4'h7; guess_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; guess_valid = 1'b0;
      chk($sformatf("t2_quiet%0d", k), o1, ev(1,0,0,0,0,1,1,0));
    end

    // Logout while checking index 2
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick; tick;
      guess = mem[i]; guess_valid = 1'b1; tick; guess_valid = 1'b0;
    end
    chk("t4_fetch2", o1, ev(2,1,1,1,0,2,0,0));
    tick; tick;
    logout = 1'b1; tick; logout = 1'b0;
    chk("t4_logout", o1, ev(0,0,0,0,0,0,0,0));
    guess = mem[2]; guess_valid = 1'b1; tick; guess_valid = 1'b0;
    chk("t4_idle_gv", o1, ev(0,0,0,0,0,0,0,0));
    start = 1'b1; tick; start = 1'b0;
    chk("t4_restart", o1, ev(0,1,1,0,0,0,0,0));

    // Reset mid-WAIT, release together with start
    tick;
    rst = 1'b1; tick;
    chk("t5_rst", o1, ev(0,0,0,0,0,0,0,0));
    rst = 1'b0; start = 1'b1; tick; start = 1'b0;
    chk("t5_fetch", o1, ev(0,1,1,0,0,0,0,0));
    tick; tick;
    guess = 4'h3; guess_valid = 1'b1; tick; guess_valid = 1'b0;
    chk("t5_match", o1, ev(1,1,1,1,0,1,0,0));

    // enable low outranks a guess in CHECK
    tick; tick;
    enable = 1'b0; guess = 4'h7; guess_valid = 1'b1; tick;
    guess_valid = 1'b0; enable = 1'b1;
    chk("en_low", o1, ev(0,0,0,0,0,0,0,0));

    // RD_LAT=3: strobe during WAIT ignored, strobe in CHECK matches
    start3 = 1'b1; tick; start3 = 1'b0;
    chk("t3_fetch", o3, ev(0,1,1,0,0,0,0,0));
    tick;
    guess3 = 4'h3; gv3 = 1'b1; tick; gv3 = 1'b0;
    chk("t3_wait_gv", o3, ev(0,0,1,0,0,0,0,0));
    tick; tick;
    chk("t3_check", o3, ev(0,0,1,0,0,0,0,0));
    gv3 = 1'b1; tick; gv3 = 1'b0;
    chk("t3_match", o3, ev(1,1,1,1,0,1,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
